// File: rtl/dma_controller_pkg.sv
// Shared constants and types for the block-move DMA controller.
// Holds the word/block geometry and the FSM state encodings.
package dma_controller_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int DEVICE_BIT_LEN = 2;
  localparam int BLOCK_WORDS    = 4;
  localparam int BLOCK_BITS     = WORD_SIZE * BLOCK_WORDS;

  localparam logic [DEVICE_BIT_LEN-1:0] DEVICE_IDLE_OFFSET = 2'd3;
  localparam logic [DEVICE_BIT_LEN-1:0] LAST_WORD          = 2'(BLOCK_WORDS - 1);

  typedef logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] block_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dma_controller_if.sv
// CPU command, bus arbitration, device and memory signals of the DMA controller.
// master = controller side, slave = CPU/device/memory side.
interface dma_controller_if;
  import dma_controller_pkg::*;

  logic                      cmd_valid;
  logic [WORD_SIZE-1:0]      cmd_addr;
  logic [DEVICE_BIT_LEN-1:0] cmd_blocks;
  logic                      br;
  logic                      bg;
  logic [DEVICE_BIT_LEN-1:0] dev_offset;
  logic [BLOCK_BITS-1:0]     dev_data;
  logic                      mem_write;
  logic [WORD_SIZE-1:0]      mem_addr;
  logic [WORD_SIZE-1:0]      mem_wdata;
  logic                      mem_ack;
  logic                      busy;
  logic                      done_int;

  modport master (
    input  cmd_valid, cmd_addr, cmd_blocks, bg, dev_data, mem_ack,
    output br, dev_offset, mem_write, mem_addr, mem_wdata, busy, done_int
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_blocks, bg, dev_data, mem_ack,
    input  br, dev_offset, mem_write, mem_addr, mem_wdata, busy, done_int
  );

endinterface

// File: rtl/dma_controller.sv
// Moves 1..3 four-word device blocks into memory while holding the CPU bus.
// Outputs are decoded from registered state so reset forces them in the same cycle.
module dma_controller
  import dma_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  dma_controller_if.master bus
);

  state_t                    state_q, state_d;
  logic [WORD_SIZE-1:0]      base_q, base_d;
  logic [DEVICE_BIT_LEN-1:0] nblk_q, nblk_d;
  logic [DEVICE_BIT_LEN-1:0] blk_q, blk_d;
  logic [DEVICE_BIT_LEN-1:0] word_q, word_d;
  block_t                    buf_q, buf_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      nblk_q  <= '0;
      blk_q   <= '0;
      word_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      nblk_q  <= nblk_d;
      blk_q   <= blk_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
    end
  end

  // Every LOAD/WRITE transition is gated by bg, so a dropped grant freezes the transfer.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    nblk_d  = nblk_q;
    blk_d   = blk_q;
    word_d  = word_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd_blocks != '0) begin
          base_d  = bus.cmd_addr;
          nblk_d  = bus.cmd_blocks;
          blk_d   = '0;
          word_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bg) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.bg) begin
          buf_d   = bus.dev_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.bg && bus.mem_ack) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            if (blk_q == nblk_q - 1'b1) begin
              state_d = S_DONE;
            end else begin
              blk_d   = blk_q + 1'b1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.br         = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done_int   = (state_q == S_DONE);
  assign bus.dev_offset = ((state_q == S_LOAD) || (state_q == S_WRITE)) ? blk_q : DEVICE_IDLE_OFFSET;
  assign bus.mem_write  = (state_q == S_WRITE) && bus.bg;
  // {block, word} is exactly 4*block + word; the 16-bit add wraps naturally.
  assign bus.mem_addr   = base_q + WORD_SIZE'({blk_q, word_q});
  assign bus.mem_wdata  = buf_q[word_q];

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low; ports clk and reset_n.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  reset_n  in  1  async active-low reset
  cmd_valid  in  1  CPU start strobe, sampled in IDLE only
  cmd_addr  in  16  memory base word address
  cmd_blocks  in  2  blocks to move (1..3); 0 = no-op
  br  out  1  bus request to CPU
  bg  in  1  bus grant from CPU
  dev_offset  out  2  device block select; 3 = idle (device floats data)
  dev_data  in  64  device block, word0 = bits[15:0]
  mem_write  out  1  memory write request
  mem_addr  out  16  memory word address
  mem_wdata  out  16  memory write word
  mem_ack  in  1  memory accepted current word this edge
  busy  out  1  high in every state except IDLE
  done_int  out  1  one-cycle completion interrupt

Function
REQ-003 FSM states SHALL be IDLE, REQ, LOAD, WRITE, DONE.
REQ-004 IDLE: cmd_valid=1 with cmd_blocks!=0 SHALL latch cmd_addr and cmd_blocks, clear block counter and word counter, enter REQ next edge; cmd_blocks=0 SHALL be ignored.
REQ-005 REQ: br=1; on bg=1 at an edge SHALL go to LOAD.
REQ-006 LOAD (one cycle): dev_offset=block counter; at the closing edge SHALL capture dev_data into a 64-bit buffer, go to WRITE.
REQ-007 WRITE: mem_write=1 only while bg=1; mem_wdata = buffer word[word counter]; mem_addr = base + 4*block + word, modulo 2^16.
REQ-008 WRITE: mem_ack=1 with bg=1 at an edge SHALL advance word counter; after word 3, advance block counter and go to LOAD, or go to DONE if that was the last block.
REQ-009 bg=0 during LOAD or WRITE SHALL pause: mem_write=0, counters, buffer, and state held, br held 1; resume on bg=1; mem_ack while bg=0 SHALL be ignored.
REQ-010 br SHALL be 1 in REQ, LOAD, WRITE and 0 in IDLE, DONE; the bus is held for the whole transfer.
REQ-011 DONE: done_int=1 for exactly one cycle, dev_offset=3, then IDLE.
REQ-012 cmd_valid while busy=1 SHALL be ignored (no queueing).
REQ-013 dev_offset SHALL be 3 in all states except LOAD, WRITE.
REQ-014 Minimum latency with bg=1 and mem_ack tied 1: cmd_valid edge -> done_int = 2 + 5*blocks cycles.

Reset
REQ-015 reset_n=0 SHALL immediately force IDLE, br=0, busy=0, done_int=0, mem_write=0, mem_addr=0, mem_wdata=0, dev_offset=3, counters and buffer 0.
REQ-016 Reset mid-transfer SHALL abandon the transfer with no done_int; partial memory writes stand.

Structure
REQ-017 WORD_SIZE(16), DEVICE_BIT_LEN(2), BLOCK_WORDS(4), DEVICE_IDLE_OFFSET(3), and state encodings SHALL live in the shared defines header.
REQ-018 Single module; no sub-module; address adder and word mux inline.

Verification
REQ-019 cmd_addr=0x0100, blocks=3, bg follows br, mem_ack=1 -> 12 writes to 0x0100..0x010B in device word order, done_int 1 cycle at edge 17.
REQ-020 blocks=1, bg held 0 for 10 cycles -> br=1, mem_write=0 throughout; transfer completes after bg rises.
REQ-021 bg dropped 3 cycles after word 1 of block 0 -> mem_write=0 while bg low, word 2 resumes at same address, no word lost or duplicated.
REQ-022 cmd_addr=0xFFFE, blocks=1 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-023 reset_n pulsed low during WRITE of block 1 -> outputs at reset values same cycle, no done_int; new command then runs normally.
REQ-024 cmd_blocks=0, and cmd_valid repeated while busy -> no br, no extra transfer.
